// File: rtl/cmp_seq_if.sv
// Operand/result handshake bundle for the sequential comparator.
// The slave modport is the comparator side; the master modport is the requester side.
interface cmp_seq_if #(
    parameter int W = 32
);
    logic         i_in_vld;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_in_rdy;
    logic         o_out_vld;
    logic         i_out_rdy;
    logic         o_eq;
    logic         o_gt;
    logic         o_lt;
    logic         o_busy;

    modport slave (
        input  i_in_vld, i_a, i_b, i_out_rdy,
        output o_in_rdy, o_out_vld, o_eq, o_gt, o_lt, o_busy
    );

    modport master (
        output i_in_vld, i_a, i_b, i_out_rdy,
        input  o_in_rdy, o_out_vld, o_eq, o_gt, o_lt, o_busy
    );
endinterface

// File: rtl/cmp_seq.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices MSB-first and stops
// at the first differing slice, returning one-hot eq/gt/lt over a handshake.
module cmp_seq #(
    parameter int W         = 32,
    parameter int CHUNK     = 8,
    parameter bit IS_SIGNED = 1'b1
) (
    input  logic      clk,
    input  logic      arst_n,
    cmp_seq_if.slave  bus
);
    localparam int N  = W / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]    IDX_TOP  = IW'(N - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic [CHUNK-1:0] s_a_s, s_b_s, k_a_s, k_b_s;
    logic           sa_gt_s, sa_lt_s;

    function automatic logic [CHUNK-1:0] slice_of(input logic [W-1:0] v, input logic [IW-1:0] i);
        logic [W-1:0] sh;
        sh = v >> (i * CHUNK);
        return sh[CHUNK-1:0];
    endfunction

    // Slice compare; flipping the sign bit of the top slice turns a signed compare into an unsigned one.
    always_comb begin
        s_a_s = slice_of(a_q, idx_q);
        s_b_s = slice_of(b_q, idx_q);
        if (IS_SIGNED && (idx_q == IDX_TOP)) begin
            k_a_s = s_a_s ^ MSB_MASK;
            k_b_s = s_b_s ^ MSB_MASK;
        end else begin
            k_a_s = s_a_s;
            k_b_s = s_b_s;
        end
        sa_gt_s = (k_a_s > k_b_s);
        sa_lt_s = (k_a_s < k_b_s);
    end

    // Next-state and datapath update for the IDLE/CMP/DONE walk.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_in_vld) begin
                    a_d     = bus.i_a;
                    b_d     = bus.i_b;
                    idx_d   = IDX_TOP;
                    state_d = ST_CMP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMP: begin
                if (sa_gt_s) begin
                    gt_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (sa_lt_s) begin
                    lt_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.i_out_rdy) begin
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                eq_d    = 1'b0;
                gt_d    = 1'b0;
                lt_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and operand registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.o_in_rdy  = (state_q == ST_IDLE);
    assign bus.o_out_vld = (state_q == ST_DONE);
    assign bus.o_busy    = (state_q == ST_CMP);
    assign bus.o_eq      = eq_q;
    assign bus.o_gt      = gt_q;
    assign bus.o_lt      = lt_q;
endmodule

// File: tb/tb_cmp_seq.sv
// Directed and streaming bench for cmp_seq; a signed and an unsigned instance
// run in lockstep on the same stimulus.
module tb_cmp_seq;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b0;
    logic [31:0] a_r = 32'h0;
    logic [31:0] b_r = 32'h0;
    int          n_total = 0;
    int          n_bad = 0;

    cmp_seq_if #(.W(32)) if_s ();
    cmp_seq_if #(.W(32)) if_u ();

    assign if_s.i_in_vld = in_vld;
    assign if_s.i_a = a_r;
    assign if_s.i_b = b_r;
    assign if_s.i_out_rdy = out_rdy;
    assign if_u.i_in_vld = in_vld;
    assign if_u.i_a = a_r;
    assign if_u.i_b = b_r;
    assign if_u.i_out_rdy = out_rdy;

    cmp_seq #(.W(32), .CHUNK(8), .IS_SIGNED(1'b1)) u_dut_s (.clk(clk), .arst_n(arst_n), .bus(if_s));
    cmp_seq #(.W(32), .CHUNK(8), .IS_SIGNED(1'b0)) u_dut_u (.clk(clk), .arst_n(arst_n), .bus(if_u));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] flags_s();
        return {if_s.o_eq, if_s.o_gt, if_s.o_lt};
    endfunction

    function automatic logic [2:0] flags_u();
        return {if_u.o_eq, if_u.o_gt, if_u.o_lt};
    endfunction

    // slices examined: position of first differing byte from the top
    function automatic int slices_of(input logic [31:0] a, input logic [31:0] b);
        for (int i = 3; i >= 0; i--) begin
            if (a[i*8 +: 8] != b[i*8 +: 8]) return 4 - i;
        end
        return 4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation with out_rdy high; in_vld stays at hold_vld afterwards.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int k, input logic [2:0] fs, input logic [2:0] fu, input logic hold_vld);
        int lat;
        int busy_cnt;
        a_r = a;
        b_r = b;
        in_vld = 1'b1;
        out_rdy = 1'b1;
        check({tag, "_rdy_pre"}, 32'(if_s.o_in_rdy), 32'd1);
        step();
        in_vld = hold_vld;
        a_r = ~a;
        b_r = b ^ 32'h5A5A_A5A5;
        check({tag, "_busy"}, 32'(if_s.o_busy), 32'd1);
        lat = 1;
        busy_cnt = 1;
        while (!if_s.o_out_vld && lat < 12) begin
            step();
            lat++;
            if (if_s.o_busy) busy_cnt++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(k + 1));
        check({tag, "_busycnt"}, 32'(busy_cnt), 32'(k));
        check({tag, "_flags_s"}, 32'(flags_s()), 32'(fs));
        check({tag, "_flags_u"}, 32'(flags_u()), 32'(fu));
        check({tag, "_vld_u"}, 32'(if_u.o_out_vld), 32'd1);
        step();
        check({tag, "_post_vld"}, 32'(if_s.o_out_vld), 32'd0);
        check({tag, "_post_rdy"}, 32'(if_s.o_in_rdy), 32'd1);
        check({tag, "_post_flags"}, 32'(flags_s()), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  es;
        logic [2:0]  eu;
        int          sel;

        // reset state while arst_n is low
        #12;
        check("rst_rdy", 32'(if_s.o_in_rdy), 32'd1);
        check("rst_vld", 32'(if_s.o_out_vld), 32'd0);
        check("rst_busy", 32'(if_s.o_busy), 32'd0);
        check("rst_flags", 32'(flags_s()), 32'd0);
        arst_n = 1'b1;
        step();

        // flags packed {eq,gt,lt}
        do_op("eq",      32'h1234_5678, 32'h1234_5678, 4, 3'b100, 3'b100, 1'b0);
        do_op("sgn",     32'h8000_0000, 32'h0000_0001, 1, 3'b001, 3'b010, 1'b0);
        do_op("lowb",    32'h0000_00FF, 32'h0000_00FE, 4, 3'b010, 3'b010, 1'b0);
        do_op("neg",     32'hFFFF_FFFF, 32'hFFFF_FFFE, 4, 3'b010, 3'b010, 1'b0);
        do_op("top",     32'h7F00_0000, 32'h8000_0000, 1, 3'b010, 3'b001, 1'b0);
        do_op("byte2",   32'h1234_0000, 32'h1235_0000, 2, 3'b001, 3'b001, 1'b0);

        // back-pressure with competing operands on the inputs
        a_r = 32'h8000_0000;
        b_r = 32'h0000_0001;
        in_vld = 1'b1;
        out_rdy = 1'b0;
        step();
        in_vld = 1'b0;
        step();
        check("bp_vld", 32'(if_s.o_out_vld), 32'd1);
        in_vld = 1'b1;
        a_r = 32'h0000_0005;
        b_r = 32'h0000_0005;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_vld", 32'(if_s.o_out_vld), 32'd1);
            check("bp_hold_rdy", 32'(if_s.o_in_rdy), 32'd0);
            check("bp_hold_fs", 32'(flags_s()), 32'(3'b001));
            check("bp_hold_fu", 32'(flags_u()), 32'(3'b010));
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        step();
        check("bp_rel_vld", 32'(if_s.o_out_vld), 32'd0);
        check("bp_rel_rdy", 32'(if_s.o_in_rdy), 32'd1);
        step();
        check("bp_once", 32'(if_s.o_out_vld), 32'd0);
        check("bp_nocap", 32'(if_s.o_busy), 32'd0);

        // reset during the second CMP cycle of an equal compare
        a_r = 32'hCAFE_F00D;
        b_r = 32'hCAFE_F00D;
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        step();
        check("mr_busy_pre", 32'(if_s.o_busy), 32'd1);
        arst_n = 1'b0;
        #1;
        check("mr_rdy", 32'(if_s.o_in_rdy), 32'd1);
        check("mr_busy", 32'(if_s.o_busy), 32'd0);
        check("mr_vld", 32'(if_s.o_out_vld), 32'd0);
        check("mr_flags", 32'(flags_s()), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("mr_novld", 32'(if_s.o_out_vld), 32'd0);
            check("mr_idle", 32'(if_s.o_in_rdy), 32'd1);
        end

        // streaming against the reference compare, in_vld held high
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 5) rb = $urandom;
            else if (sel == 4) rb = ra;
            else rb = ra ^ (32'($urandom_range(1, 255)) << (8 * sel));
            es = ($signed(ra) == $signed(rb)) ? 3'b100 :
                 (($signed(ra) > $signed(rb)) ? 3'b010 : 3'b001);
            eu = (ra == rb) ? 3'b100 : ((ra > rb) ? 3'b010 : 3'b001);
            do_op("stream", ra, rb, slices_of(ra, rb), es, eu, 1'b1);
        end
        in_vld = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/cmp_seq.md
# cmp_seq

Multi-cycle sequential magnitude comparator for area-constrained paths where a full-width parallel compare is too costly. It accepts two W-bit operands over a valid/ready handshake and walks them CHUNK bits at a time, most-significant slice first. It stops at the first differing slice and returns one-hot eq/gt/lt flags over a second valid/ready handshake. It serves as the low-area counterpart of the single-cycle comparator in the common library and has identical result semantics.

## Interface

- W, 32: operand width. W % CHUNK must be 0.
- CHUNK, 8: slice width examined per cycle. N = W/CHUNK.
- IS_SIGNED, 1: 1 selects two's-complement comparison; 0 selects unsigned comparison.

Ports:

- clk, in, 1: clock. All state updates on the rising edge.
- arst_n, in, 1: reset. Asynchronous, active-low.
- i_in_vld, in, 1: operand pair valid.
- i_a, in, W: operand A.
- i_b, in, W: operand B.
- o_in_rdy, out, 1: block can accept operands.
- o_out_vld, out, 1: result valid.
- i_out_rdy, in, 1: downstream accepts result.
- o_eq, out, 1: A == B.
- o_gt, out, 1: A > B.
- o_lt, out, 1: A < B.
- o_busy, out, 1: comparison in progress (state CMP).

## Operation

- FSM states are IDLE, CMP and DONE. Reset enters IDLE.
- IDLE:
  - o_in_rdy=1.
  - On i_in_vld & o_in_rdy: capture i_a/i_b into registers a_q/b_q, set idx=N-1, go to CMP.
- CMP, one slice per cycle, s_a = a_q[idx*CHUNK +: CHUNK], s_b likewise:
  - If idx==N-1 and IS_SIGNED: compare the slices as signed (slice MSB is the operand sign bit). Otherwise compare unsigned.
  - s_a > s_b: gt_q=1, go to DONE.
  - s_a < s_b: lt_q=1, go to DONE.
  - Equal and idx==0: eq_q=1, go to DONE.
  - Equal and idx>0: idx decrements, stay in CMP.
- DONE:
  - o_out_vld=1 and flags are driven from eq_q/gt_q/lt_q.
  - On i_out_rdy: clear flags, go to IDLE.
- o_in_rdy = (state==IDLE). There is no bypass, so a new operand is never accepted in the same cycle a result handshakes.
- In DONE exactly one of o_eq/o_gt/o_lt is 1. In IDLE and CMP all three flags are 0.
- i_a/i_b are sampled only at acceptance. Later changes on the inputs have no effect.
- idx width is $clog2(N), with a minimum of 1. It never wraps below 0, because CMP exits at idx==0.
- N==1 degenerates to a single-cycle CMP with the full signed or unsigned rule.

## Timing

- Reset values: state=IDLE, o_in_rdy=1 (including while arst_n is low), o_out_vld=0, o_eq=o_gt=o_lt=0, o_busy=0, idx=0.
- Acceptance at edge T0 puts the FSM in CMP during cycle T0+1.
- Decision at slice k (k = 1..N slices examined) occurs at edge T0+k. o_out_vld is high in cycle T0+k+1.
- Latency from acceptance to o_out_vld is k+1 cycles: best case 2, worst case N+1.
- Result handshake at edge T1 puts the FSM in IDLE in cycle T1+1. The next acceptance can occur at edge T1+1.
- Minimum per-operation period is k+2 cycles.
- Back-pressure: while i_out_rdy=0 in DONE, o_out_vld and the flags hold stable indefinitely and o_in_rdy stays 0.
- i_in_vld asserted outside IDLE is ignored, and no capture occurs.
- Reset asserted mid-CMP or in DONE clears state and outputs immediately (asynchronously). The in-flight result is discarded and is never presented.

## Test plan

- W=32/CHUNK=8/IS_SIGNED=1, A=B=0x1234_5678: o_eq=1, gt=lt=0; o_out_vld rises 5 cycles after acceptance; o_busy high for 4 cycles.
- A=0x8000_0000, B=0x0000_0001:
  - With IS_SIGNED=1: o_lt=1 after 1 CMP cycle (o_out_vld 2 cycles after acceptance).
  - With IS_SIGNED=0: o_gt=1 at the same latency.
- A=0x0000_00FF, B=0x0000_00FE: o_gt=1 after 4 CMP cycles. Also A=0xFFFF_FFFF, B=0xFFFF_FFFE (signed -1 vs -2): o_gt=1 after 4 CMP cycles.
- Back-pressure: hold i_out_rdy=0 for 10 cycles in DONE with i_in_vld=1 and different operands on i_a/i_b. Required: flags stable, o_in_rdy=0, no capture. After releasing i_out_rdy, the original result handshakes exactly once.
- Reset mid-operation: drop arst_n during the 2nd CMP cycle of an equal-operand compare. Required: outputs return to reset values immediately; after release, o_in_rdy=1 and no o_out_vld pulse appears.
- Streaming: hold i_in_vld=1 and i_out_rdy=1 with random operands for 1000 operations. Required: each result matches the reference $signed/unsigned compare, and acceptance follows each result handshake by exactly 1 cycle.
